// File: rtl/n64a_demux_ctrl_if.sv
// Demux-side bus: sync nibble strobe coming from the demux, parameter word going back to it.
interface n64a_demux_ctrl_if;
    logic       vdata_valid_0;
    logic [3:0] vdata_r_sy_0;
    logic [2:0] demuxparams_o;

    modport master (output vdata_valid_0, output vdata_r_sy_0, input demuxparams_o);
    modport slave  (input vdata_valid_0, input vdata_r_sy_0, output demuxparams_o);
endinterface

// File: rtl/n64a_demux_ctrl.sv
// Field-level video mode classifier; drives {palmode, ndo_deblur, n16bit_mode} to the demux
// and only lets that word change on field boundaries while locked.
module n64a_demux_ctrl #(
    parameter int unsigned LINES_MIN = 240,
    parameter int unsigned LINES_MAX = 330,
    parameter int unsigned LINES_PAL = 288
) (
    input  logic             VCLK,
    input  logic             RST,
    n64a_demux_ctrl_if.slave demux,
    input  logic [1:0]       cfg_deblur,
    input  logic             cfg_n16bit_mode,
    output logic             vmode_locked,
    output logic             interlaced_o,
    output logic [9:0]       field_lines_o
);
    localparam logic [9:0] LinesMin   = 10'(LINES_MIN);
    localparam logic [9:0] LinesMax   = 10'(LINES_MAX);
    localparam logic [9:0] LinesPal   = 10'(LINES_PAL);
    localparam logic [9:0] LineCntMax = 10'h3FF;

    typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

    state_e     r_state, w_state_next;
    logic [3:0] r_sy_prev;
    logic [9:0] r_line_cnt, w_line_cnt_next;
    logic [9:0] r_field_lines, w_field_lines_next;
    logic [9:0] r_prev_valid_cnt, w_prev_valid_cnt_next;
    logic       r_interlaced, w_interlaced_next;
    logic       r_class, w_class_next;      // 1 = PAL
    logic       r_qual, w_qual_next;        // one qualifying field already seen in MEASURE
    logic       r_pending, w_pending_next;  // one deviant-class field seen while locked
    logic [2:0] r_params, w_params_next;

    logic w_hs_evt, w_vs_evt, w_field_valid, w_field_pal, w_sat, w_diff1, w_deblur;

    assign w_hs_evt      = demux.vdata_valid_0 && r_sy_prev[1] && !demux.vdata_r_sy_0[1];
    assign w_vs_evt      = demux.vdata_valid_0 && r_sy_prev[3] && !demux.vdata_r_sy_0[3];
    assign w_field_valid = (r_line_cnt >= LinesMin) && (r_line_cnt <= LinesMax);
    assign w_field_pal   = (r_line_cnt >= LinesPal);
    assign w_sat         = w_hs_evt && !w_vs_evt && (r_line_cnt == LineCntMax);
    assign w_diff1       = (r_line_cnt == r_prev_valid_cnt + 10'd1) ||
                           (r_prev_valid_cnt == r_line_cnt + 10'd1);

    always_comb begin
        w_state_next          = r_state;
        w_line_cnt_next       = r_line_cnt;
        w_field_lines_next    = r_field_lines;
        w_prev_valid_cnt_next = r_prev_valid_cnt;
        w_interlaced_next     = r_interlaced;
        w_class_next          = r_class;
        w_qual_next           = r_qual;
        w_pending_next        = r_pending;
        w_params_next         = r_params;
        w_deblur              = 1'b0;

        // A coincident hsync belongs to the field that starts here.
        if (w_vs_evt) begin
            w_field_lines_next = r_line_cnt;
            w_line_cnt_next    = w_hs_evt ? 10'd1 : 10'd0;
        end else if (w_hs_evt && r_line_cnt != LineCntMax) begin
            w_line_cnt_next = r_line_cnt + 10'd1;
        end

        case (r_state)
            StSearch: begin
                if (w_vs_evt) begin
                    w_state_next = StMeasure;
                    w_qual_next  = 1'b0;
                end
            end
            StMeasure: begin
                if (w_vs_evt) begin
                    if (w_field_valid) begin
                        w_interlaced_next     = w_diff1;
                        w_prev_valid_cnt_next = r_line_cnt;
                        if (r_qual && w_field_pal == r_class) begin
                            w_state_next   = StLocked;
                            w_pending_next = 1'b0;
                        end else begin
                            w_class_next = w_field_pal;
                            w_qual_next  = 1'b1;
                        end
                    end else begin
                        w_qual_next = 1'b0;
                    end
                end
            end
            StLocked: begin
                if (w_sat || (w_vs_evt && !w_field_valid)) begin
                    w_state_next      = StSearch;
                    w_interlaced_next = 1'b0;
                    w_pending_next    = 1'b0;
                end else if (w_vs_evt) begin
                    w_interlaced_next     = w_diff1;
                    w_prev_valid_cnt_next = r_line_cnt;
                    if (w_field_pal == r_class) begin
                        w_pending_next = 1'b0;
                    end else if (r_pending) begin
                        w_class_next   = w_field_pal;
                        w_pending_next = 1'b0;
                    end else begin
                        w_pending_next = 1'b1;
                    end
                end
            end
            default: w_state_next = StSearch;
        endcase

        w_deblur = (cfg_deblur == 2'b01) ||
                   (cfg_deblur == 2'b10 && w_state_next == StLocked && !w_interlaced_next);

        // Unlocked: palmode frozen, deblur off, n16bit tracks cfg; locked: whole word per field.
        if (w_state_next != StLocked) begin
            w_params_next = {r_params[2], 1'b1, cfg_n16bit_mode};
        end else if (w_vs_evt) begin
            w_params_next = {w_class_next, !w_deblur, cfg_n16bit_mode};
        end
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            r_state          <= StSearch;
            r_sy_prev        <= 4'hF;
            r_line_cnt       <= 10'd0;
            r_field_lines    <= 10'd0;
            r_prev_valid_cnt <= 10'd0;
            r_interlaced     <= 1'b0;
            r_class          <= 1'b0;
            r_qual           <= 1'b0;
            r_pending        <= 1'b0;
            r_params         <= 3'b011;
        end else begin
            if (demux.vdata_valid_0) begin
                r_sy_prev <= demux.vdata_r_sy_0;
            end
            r_state          <= w_state_next;
            r_line_cnt       <= w_line_cnt_next;
            r_field_lines    <= w_field_lines_next;
            r_prev_valid_cnt <= w_prev_valid_cnt_next;
            r_interlaced     <= w_interlaced_next;
            r_class          <= w_class_next;
            r_qual           <= w_qual_next;
            r_pending        <= w_pending_next;
            r_params         <= w_params_next;
        end
    end

    assign demux.demuxparams_o = r_params;
    assign vmode_locked        = (r_state == StLocked);
    assign interlaced_o        = r_interlaced;
    assign field_lines_o       = r_field_lines;

endmodule

// File: tb/tb_n64a_demux_ctrl.sv
// Self-checking bench for n64a_demux_ctrl: vector table, directed field sequences and
// randomized field streams against a field-level reference model.
module tb_n64a_demux_ctrl;
    localparam int LMIN = 240;
    localparam int LMAX = 330;
    localparam int LPAL = 288;

    logic       VCLK = 1'b0;
    logic       RST;
    logic [1:0] cfg_deblur;
    logic       cfg_n16bit_mode;
    logic       vmode_locked;
    logic       interlaced_o;
    logic [9:0] field_lines_o;

    n64a_demux_ctrl_if bus();

    n64a_demux_ctrl #(
        .LINES_MIN(LMIN),
        .LINES_MAX(LMAX),
        .LINES_PAL(LPAL)
    ) dut (
        .VCLK           (VCLK),
        .RST            (RST),
        .demux          (bus),
        .cfg_deblur     (cfg_deblur),
        .cfg_n16bit_mode(cfg_n16bit_mode),
        .vmode_locked   (vmode_locked),
        .interlaced_o   (interlaced_o),
        .field_lines_o  (field_lines_o)
    );

    always #5 VCLK = ~VCLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_every = 1'b0;
    int g_lo = 0;
    int g_hi = 0;

    // Reference model: field bookkeeping in plain integers.
    logic [3:0] m_prev;
    int         m_count, m_lines, m_prev_valid, m_run, m_dev;
    bit         m_search, m_locked, m_cls, m_inter;
    logic [2:0] m_params;

    task automatic model_reset();
        m_prev = 4'hF; m_count = 0; m_lines = 0; m_prev_valid = 0; m_run = 0; m_dev = 0;
        m_search = 1'b1; m_locked = 1'b0; m_cls = 1'b0; m_inter = 1'b0; m_params = 3'b011;
    endtask

    task automatic model_lose_lock();
        m_locked = 1'b0; m_search = 1'b1; m_inter = 1'b0; m_dev = 0;
        m_params[1] = 1'b1; m_params[0] = cfg_n16bit_mode;
    endtask

    task automatic model_end_field(input int n);
        bit ok, pal, deblur;
        ok  = (n >= LMIN) && (n <= LMAX);
        pal = (n >= LPAL);
        m_lines = n;
        if (m_search) begin
            m_search = 1'b0;
            m_run = 0;
            return;
        end
        if (!ok) begin
            if (m_locked) model_lose_lock();
            else m_run = 0;
            return;
        end
        m_inter = ((n - m_prev_valid) == 1) || ((m_prev_valid - n) == 1);
        m_prev_valid = n;
        if (!m_locked) begin
            if (m_run > 0 && pal == m_cls) m_run++;
            else begin m_cls = pal; m_run = 1; end
            if (m_run >= 2) begin m_locked = 1'b1; m_dev = 0; end
        end else if (pal == m_cls) begin
            m_dev = 0;
        end else begin
            m_dev++;
            if (m_dev >= 2) begin m_cls = pal; m_dev = 0; end
        end
        if (m_locked) begin
            deblur = (cfg_deblur == 2'd1) || (cfg_deblur == 2'd2 && !m_inter);
            m_params = {m_cls, !deblur, cfg_n16bit_mode};
        end
    endtask

    task automatic model_edge();
        bit hs, vs;
        logic [3:0] sy;
        if (RST) begin model_reset(); return; end
        if (!m_locked) begin m_params[1] = 1'b1; m_params[0] = cfg_n16bit_mode; end
        if (bus.vdata_valid_0) begin
            sy = bus.vdata_r_sy_0;
            hs = m_prev[1] && !sy[1];
            vs = m_prev[3] && !sy[3];
            m_prev = sy;
            if (vs) begin
                model_end_field(m_count);
                m_count = hs ? 1 : 0;
            end else if (hs) begin
                if (m_count == 1023) begin
                    if (m_locked) model_lose_lock();
                end else begin
                    m_count++;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".params"}, 32'(bus.demuxparams_o), 32'(m_params));
        chk({tag, ".locked"}, 32'(vmode_locked), 32'(m_locked));
        chk({tag, ".interlaced"}, 32'(interlaced_o), 32'(m_inter));
        chk({tag, ".lines"}, 32'(field_lines_o), 32'(m_lines));
    endtask

    function automatic logic [3:0] nib(input logic vs_n, input logic hs_n);
        logic [1:0] r;
        r = 2'($urandom);
        return {vs_n, r[1], hs_n, r[0]};
    endfunction

    task automatic tick(input logic v, input logic [3:0] sy);
        bus.vdata_valid_0 = v;
        bus.vdata_r_sy_0  = sy;
        @(posedge VCLK);
        #1;
        model_edge();
        if (chk_every) check_all("cycle");
    endtask

    task automatic strobe(input logic [3:0] sy);
        int gap;
        gap = int'($urandom_range(g_hi, g_lo));
        tick(1'b1, sy);
        for (int i = 0; i < gap; i++) tick(1'b0, 4'($urandom));
    endtask

    task automatic send_lines(input int n);
        for (int i = 0; i < n; i++) begin
            strobe(nib(1'b1, 1'b0));
            strobe(nib(1'b1, 1'b1));
        end
    endtask

    task automatic send_vsync(input bit coin);
        tick(1'b1, nib(1'b0, coin ? 1'b0 : 1'b1));
        check_all("vsync");
        strobe(nib(1'b0, 1'b1));
        strobe(nib(1'b1, 1'b1));
    endtask

    task automatic send_field(input int n);
        send_lines(n);
        send_vsync(1'b0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(1'b1, nib(1'b1, 1'b0));
        RST = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [3:0] sy;
        logic       n16;
        logic [2:0] e_par;
        logic [9:0] e_lines;
        logic       e_lock;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lens[6];
        bus.vdata_valid_0 = 1'b0;
        bus.vdata_r_sy_0  = 4'hF;
        cfg_deblur        = 2'b10;
        cfg_n16bit_mode   = 1'b1;
        RST               = 1'b1;

        // Edge detection, strobe gating, coincident edges and n16 pass-through.
        tbl[0]  = '{1'b1, 4'hF, 1'b1, 3'b011, 10'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'hD, 1'b1, 3'b011, 10'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'h5, 1'b1, 3'b011, 10'd0, 1'b0};
        tbl[3]  = '{1'b1, 4'hD, 1'b1, 3'b011, 10'd0, 1'b0};
        tbl[4]  = '{1'b1, 4'hF, 1'b1, 3'b011, 10'd0, 1'b0};
        tbl[5]  = '{1'b1, 4'hD, 1'b1, 3'b011, 10'd0, 1'b0};
        tbl[6]  = '{1'b1, 4'h7, 1'b1, 3'b011, 10'd2, 1'b0};
        tbl[7]  = '{1'b1, 4'hF, 1'b0, 3'b010, 10'd2, 1'b0};
        tbl[8]  = '{1'b1, 4'h5, 1'b0, 3'b010, 10'd0, 1'b0};
        tbl[9]  = '{1'b1, 4'hF, 1'b1, 3'b011, 10'd0, 1'b0};
        tbl[10] = '{1'b1, 4'h7, 1'b1, 3'b011, 10'd1, 1'b0};
        tbl[11] = '{1'b0, 4'hF, 1'b1, 3'b011, 10'd1, 1'b0};

        do_reset();
        chk("reset.params", 32'(bus.demuxparams_o), 32'h3);
        chk("reset.locked", 32'(vmode_locked), 32'h0);
        chk("reset.interlaced", 32'(interlaced_o), 32'h0);
        chk("reset.lines", 32'(field_lines_o), 32'h0);
        for (int i = 0; i < 12; i++) begin
            cfg_n16bit_mode = tbl[i].n16;
            tick(tbl[i].v, tbl[i].sy);
            chk($sformatf("tbl%0d.params", i), 32'(bus.demuxparams_o), 32'(tbl[i].e_par));
            chk($sformatf("tbl%0d.lines", i), 32'(field_lines_o), 32'(tbl[i].e_lines));
            chk($sformatf("tbl%0d.locked", i), 32'(vmode_locked), 32'(tbl[i].e_lock));
        end

        // NTSC progressive, strobe every 4 cycles.
        g_lo = 3; g_hi = 3;
        cfg_deblur = 2'b10; cfg_n16bit_mode = 1'b1;
        do_reset();
        send_field(263);
        send_field(263);
        chk("ntsc.locked_before", 32'(vmode_locked), 32'h0);
        send_field(263);
        chk("ntsc.locked", 32'(vmode_locked), 32'h1);
        chk("ntsc.params", 32'(bus.demuxparams_o), 32'h1);
        chk("ntsc.interlaced", 32'(interlaced_o), 32'h0);
        chk("ntsc.lines", 32'(field_lines_o), 32'd263);

        // PAL interlaced.
        g_lo = 1; g_hi = 1;
        do_reset();
        send_field(312); send_field(313); send_field(312); send_field(313);
        chk("pal.locked", 32'(vmode_locked), 32'h1);
        chk("pal.params", 32'(bus.demuxparams_o), 32'h7);
        chk("pal.interlaced", 32'(interlaced_o), 32'h1);

        // Reset in the middle of a locked field; RST wins over the strobe.
        send_lines(100);
        RST = 1'b1;
        tick(1'b1, nib(1'b0, 1'b0));
        RST = 1'b0;
        chk("rst_mid.params", 32'(bus.demuxparams_o), 32'h3);
        chk("rst_mid.locked", 32'(vmode_locked), 32'h0);
        chk("rst_mid.interlaced", 32'(interlaced_o), 32'h0);
        chk("rst_mid.lines", 32'(field_lines_o), 32'h0);

        // Class hysteresis.
        g_lo = 0; g_hi = 0;
        do_reset();
        send_field(263); send_field(263); send_field(263);
        send_field(313);
        chk("hyst.one_deviant", 32'(bus.demuxparams_o[2]), 32'h0);
        send_field(263);
        send_field(313);
        chk("hyst.first_of_two", 32'(bus.demuxparams_o[2]), 32'h0);
        send_field(313);
        chk("hyst.switched", 32'(bus.demuxparams_o[2]), 32'h1);

        // Lock loss on a short field, then on counter saturation.
        send_field(150);
        chk("loss.locked", 32'(vmode_locked), 32'h0);
        chk("loss.params", 32'(bus.demuxparams_o), 32'h7);
        send_field(263); send_field(263); send_field(263);
        chk("relock.params", 32'(bus.demuxparams_o), 32'h1);
        send_lines(1023);
        chk("sat.before", 32'(vmode_locked), 32'h1);
        send_lines(1);
        chk("sat.locked", 32'(vmode_locked), 32'h0);
        chk("sat.params", 32'(bus.demuxparams_o), 32'h3);
        send_vsync(1'b0);
        chk("sat.lines", 32'(field_lines_o), 32'd1023);

        // Coincident hsync/vsync and field-boundary application of cfg_n16bit_mode.
        do_reset();
        send_field(263); send_field(263); send_field(263);
        send_lines(262);
        send_vsync(1'b1);
        chk("coin.lines_prev", 32'(field_lines_o), 32'd262);
        send_lines(100);
        cfg_n16bit_mode = 1'b0;
        send_lines(162);
        chk("n16.held", 32'(bus.demuxparams_o[0]), 32'h1);
        send_vsync(1'b0);
        chk("coin.lines", 32'(field_lines_o), 32'd263);
        chk("n16.applied", 32'(bus.demuxparams_o[0]), 32'h0);

        // Randomized field streams, every cycle compared with the model.
        chk_every = 1'b1;
        g_lo = 0; g_hi = 1;
        do_reset();
        for (int b = 0; b < 8; b++) begin
            int base;
            bit ilace;
            base  = ($urandom_range(0, 1) == 1) ? 262 : 312;
            ilace = 1'($urandom);
            cfg_deblur      = 2'($urandom);
            cfg_n16bit_mode = 1'($urandom);
            lens = '{150, 239, 240, 287, 288, 331};
            for (int f = 0; f < 5; f++) begin
                int n;
                if ($urandom_range(0, 4) == 0) n = lens[$urandom_range(0, 5)];
                else n = base + (ilace ? (f % 2) : 0);
                send_lines(n);
                send_vsync($urandom_range(0, 3) == 0);
            end
        end
        chk_every = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/n64a_demux_ctrl.md
# n64a_demux_ctrl

Field-level controller that configures the video demultiplexer. It watches the sync nibble captured by the demux on each data-valid strobe, counts lines per field, and classifies the incoming video as PAL/NTSC and progressive/interlaced. From that classification and the user configuration it produces the 3-bit demux parameter word {palmode, ndo_deblur, n16bit_mode}. Changes to that word are applied only at field boundaries so the demux never switches mid-field.

## Interface
Parameters:
- LINES_MIN, 240, minimum line count for a valid field
- LINES_MAX, 330, maximum line count for a valid field
- LINES_PAL, 288, a field with this many lines or more is classed PAL

Ports:
- VCLK  in  1  video clock
- RST  in  1  reset, synchronous, active-high; one clock domain only
- vdata_valid_0  in  1  one-cycle strobe from the demux: sync nibble is new
- vdata_r_sy_0  in  4  sync nibble {nVSYNC, nCLAMP, nHSYNC, nCSYNC}; sample only when vdata_valid_0=1
- cfg_deblur  in  2  00 = off, 01 = force on, 10 = auto, 11 = off
- cfg_n16bit_mode  in  1  1 = 21-bit colour pass-through, 0 = 15/16-bit reduction
- demuxparams_o  out  3  {palmode, ndo_deblur, n16bit_mode} to the demux
- vmode_locked  out  1  classification is stable
- interlaced_o  out  1  consecutive field line counts differ by exactly 1
- field_lines_o  out  10  line count of the last completed field

## Operation
- **Sync edge detection:** the previous sync nibble is held in a register that updates only on vdata_valid_0.
  - Falling nHSYNC = previous 1, current 0 → hsync event.
  - Falling nVSYNC → vsync event.
- **Line counter:** 10 bits, saturates at 1023.
  - Increments on each hsync event.
  - A vsync event ends the field:
    - field_lines_o ← count;
    - counter ← 1 if an hsync event falls in the same sample, else 0.
  - An hsync event that coincides with a vsync event counts toward the new field.
- **Field validity:** a field is valid when LINES_MIN ≤ count ≤ LINES_MAX. Its class is PAL when count ≥ LINES_PAL.
- **FSM states:** SEARCH, MEASURE, LOCKED. Reset state is SEARCH.
  - SEARCH: on the first vsync event → MEASURE. The count at that event is discarded because the field is partial.
  - MEASURE: valid field → store its class and count; after 2 consecutive valid fields of the same class → LOCKED. An invalid field restarts the 2-field qualification and stays in MEASURE.
  - LOCKED: a field of a different class sets a pending flag. A second consecutive field of that class switches palmode; one deviant field is ignored. An invalid field, or counter saturation → SEARCH.
- **interlaced_o:** updated on every valid field. Set to 1 when |count − previous valid count| = 1, else 0. Cleared when entering SEARCH.
- **Deblur decision:** deblur is active when cfg_deblur = 01, or when cfg_deblur = 10 with vmode_locked = 1 and interlaced_o = 0. ndo_deblur is the inverse of that result.
- **Parameter application:**
  - In LOCKED, demuxparams_o updates only on vsync events.
  - In SEARCH and MEASURE:
    - palmode holds its last value;
    - ndo_deblur = 1;
    - n16bit_mode follows cfg_n16bit_mode with 1 cycle of register latency.
- **Reset values:**
  - demuxparams_o = 3'b011 (NTSC, deblur off, n16bit);
  - vmode_locked = 0, interlaced_o = 0, field_lines_o = 0;
  - line counter = 0, FSM = SEARCH.

## Timing
- All state changes occur only in cycles where vdata_valid_0 = 1, except reset and the n16bit pass-through in SEARCH/MEASURE.
- An event in the strobe cycle updates counters, FSM, status outputs and demuxparams_o at the next VCLK edge, i.e. 1-cycle latency.
- vmode_locked rises on the same edge as the FSM enters LOCKED. It falls on the edge of the invalid vsync event, or on the edge where the counter saturates.
- Counter saturation is detected as count = 1023 with an hsync event pending. On that edge: → SEARCH, vmode_locked = 0.
- cfg inputs are treated as quasi-static. In LOCKED, a cfg change takes effect at the next vsync event.
- RST asserted during any cycle, mid-field or mid-qualification included, forces all reset values at that edge. RST has priority over a simultaneous strobe.

## Test plan
- **NTSC progressive lock:** 3 fields of 263 hsyncs each, strobe every 4 cycles, cfg_deblur = 10 → locked after the 3rd vsync; demuxparams_o = 3'b001, interlaced_o = 0, field_lines_o = 263.
- **PAL interlaced:** alternating fields of 312/313 lines, cfg_deblur = 10 → locked; palmode = 1, interlaced_o = 1, ndo_deblur = 1 (demuxparams_o = 3'b111).
- **Class hysteresis:** locked NTSC, then one 313-line field → palmode stays 0. Then two 313-line fields → palmode = 1 at the 2nd vsync edge.
- **Lock loss:** locked, then a 150-line field → vmode_locked = 0, FSM = SEARCH, ndo_deblur = 1, palmode unchanged. Separately, no vsync for 1023+ hsyncs → the same response.
- **Coincident edges and field-boundary application:** hsync and vsync falling in the same sample → the new field's count starts at 1. A cfg_n16bit_mode toggle mid-field while locked → demuxparams_o[0] changes only 1 cycle after the next vsync strobe.
- **Reset mid-operation:** RST pulsed mid-field while locked → next edge demuxparams_o = 3'b011, vmode_locked = 0, interlaced_o = 0, field_lines_o = 0.
